// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic edge feeder: FSM states, stream length, store selects.
package systolic_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CLEAR  = 2'd1,
    S_STREAM = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  // Number of skewed stream steps needed for the last product to reach PE(N-1,N-1).
  function automatic int stream_len(input int n, input int k);
    return k + 2 * n - 2;
  endfunction

endpackage

// File: rtl/feed_mem.sv
// Operand store: DW x (N*K) register array, one write port, N combinational read ports.
module feed_mem #(
  parameter int N  = 4,
  parameter int K  = 4,
  parameter int DW = 4,
  parameter int AW = $clog2(N*K)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [DW-1:0]   wr_data,
  input  logic [N*AW-1:0] rd_addr,
  output logic [N*DW-1:0] rd_data
);
  localparam int DEPTH = N * K;
  localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic          wr_ok;

  // Next store contents: a single in-range write, otherwise hold.
  always_comb begin
    mem_d = mem_q;
    wr_ok = wr_en && ({1'b0, wr_addr} < DEPTH_V);
    if (wr_ok) begin
      mem_d[wr_addr] = wr_data;
    end
  end

  // Store register array, cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int a = 0; a < DEPTH; a++) begin
        mem_q[a] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // Parallel read ports, one per array edge position.
  always_comb begin
    rd_data = '0;
    for (int p = 0; p < N; p++) begin
      rd_data[p*DW +: DW] = mem_q[rd_addr[p*AW +: AW]];
    end
  end

endmodule

// File: rtl/systolic_feeder.sv
// Edge feeder for an N x N output-stationary array: stores A and B, streams skewed
// zero-padded operands on the left/top edges, clears the array before each pass.
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int N  = 4,
  parameter int K  = 4,
  parameter int DW = 4,
  parameter int AW = $clog2(N*K)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic            wr_sel,
  input  logic [AW-1:0]   wr_addr,
  input  logic [DW-1:0]   wr_data,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic            arr_clr,
  output logic [N*DW-1:0] left_bus,
  output logic [N*DW-1:0] up_bus
);
  localparam int L  = stream_len(N, K);
  localparam int TW = (L > 1) ? $clog2(L) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(L - 1);

  state_t          state_q, state_d;
  logic [TW-1:0]   t_q, t_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            arr_clr_q, arr_clr_d;
  logic [N*DW-1:0] left_q, left_d;
  logic [N*DW-1:0] up_q, up_d;

  logic            store_we;
  logic [N*AW-1:0] a_rd_addr, b_rd_addr;
  logic [N*DW-1:0] a_rd_data, b_rd_data;
  logic [N-1:0]    a_vld, b_vld;

  feed_mem #(.N(N), .K(K), .DW(DW), .AW(AW)) u_mem_a (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (store_we && (wr_sel == SEL_A)),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (a_rd_addr),
    .rd_data (a_rd_data)
  );

  feed_mem #(.N(N), .K(K), .DW(DW), .AW(AW)) u_mem_b (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (store_we && (wr_sel == SEL_B)),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (b_rd_addr),
    .rd_data (b_rd_data)
  );

  // Pass sequencing: IDLE -> CLEAR -> STREAM (t = 0..L-1) -> DONE -> IDLE.
  always_comb begin
    state_d  = state_q;
    t_d      = t_q;
    store_we = wr_en && (state_q == S_IDLE);
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CLEAR;
          t_d     = '0;
        end
      end
      S_CLEAR: begin
        state_d = S_STREAM;
        t_d     = '0;
      end
      S_STREAM: begin
        if (t_q == T_LAST) begin
          state_d = S_DONE;
        end else begin
          t_d = t_q + TW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Skew addressing: row i reads A[i][t-i], column j reads B[t-j][j], valid only inside 0..K-1.
  always_comb begin
    int ka;
    int kb;
    a_vld     = '0;
    b_vld     = '0;
    a_rd_addr = '0;
    b_rd_addr = '0;
    for (int i = 0; i < N; i++) begin
      ka       = int'(t_q) - i;
      a_vld[i] = (ka >= 0) && (ka < K);
      if (a_vld[i]) begin
        a_rd_addr[i*AW +: AW] = AW'(i * K + ka);
      end
    end
    for (int j = 0; j < N; j++) begin
      kb       = int'(t_q) - j;
      b_vld[j] = (kb >= 0) && (kb < K);
      if (b_vld[j]) begin
        b_rd_addr[j*AW +: AW] = AW'(j * K + kb);
      end
    end
  end

  // Registered edge outputs: zero-padded buses during STREAM, clear/done/busy strobes.
  always_comb begin
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_q == S_DONE);
    arr_clr_d = (state_q == S_CLEAR);
    left_d    = '0;
    up_d      = '0;
    if (state_q == S_STREAM) begin
      for (int i = 0; i < N; i++) begin
        if (a_vld[i]) begin
          left_d[i*DW +: DW] = a_rd_data[i*DW +: DW];
        end
        if (b_vld[i]) begin
          up_d[i*DW +: DW] = b_rd_data[i*DW +: DW];
        end
      end
    end
  end

  // State and output registers; reset parks the FSM and holds the array in clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      t_q       <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      arr_clr_q <= 1'b1;
      left_q    <= '0;
      up_q      <= '0;
    end else begin
      state_q   <= state_d;
      t_q       <= t_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      arr_clr_q <= arr_clr_d;
      left_q    <= left_d;
      up_q      <= up_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign arr_clr  = arr_clr_q;
  assign left_bus = left_q;
  assign up_bus   = up_q;

endmodule

// File: tb/tb_systolic_feeder.sv
// Bench for systolic_feeder: drives passes into a behavioural PE array and checks
// edge streams, timing and final sums against a product scoreboard.
module tb_systolic_feeder;
  localparam int N  = 4;
  localparam int K  = 4;
  localparam int DW = 4;
  localparam int AW = 4;
  localparam int SW = 2 * DW;
  localparam int L  = K + 2 * N - 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            wr_en;
  logic            wr_sel;
  logic [AW-1:0]   wr_addr;
  logic [DW-1:0]   wr_data;
  logic            start;
  logic            busy;
  logic            done;
  logic            arr_clr;
  logic [N*DW-1:0] left_bus;
  logic [N*DW-1:0] up_bus;

  int checks = 0;
  int errors = 0;

  systolic_feeder #(.N(N), .K(K), .DW(DW), .AW(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_sel   (wr_sel),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .arr_clr  (arr_clr),
    .left_bus (left_bus),
    .up_bus   (up_bus)
  );

  always #5 clk = ~clk;

  // Behavioural output-stationary PE array fed by the DUT edges.
  logic [DW-1:0] pl [N][N];
  logic [DW-1:0] pu [N][N];
  logic [DW-1:0] lin [N][N];
  logic [DW-1:0] uin [N][N];
  logic [SW-1:0] psum [N][N];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      lin[i][0] = left_bus[i*DW +: DW];
      uin[0][i] = up_bus[i*DW +: DW];
    end
    for (int i = 0; i < N; i++) begin
      for (int j = 1; j < N; j++) begin
        lin[i][j] = pl[i][j-1];
        uin[j][i] = pu[j-1][i];
      end
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (arr_clr) begin
          pl[i][j]   <= '0;
          pu[i][j]   <= '0;
          psum[i][j] <= '0;
        end else begin
          pl[i][j]   <= lin[i][j];
          pu[i][j]   <= uin[i][j];
          psum[i][j] <= psum[i][j] + SW'(lin[i][j]) * SW'(uin[i][j]);
        end
      end
    end
  end

  int done_cnt = 0;
  always @(posedge clk) begin
    if (done === 1'b1) done_cnt <= done_cnt + 1;
  end

  int a_m [N][K];
  int b_m [K][N];
  int sb [$];
  logic [SW-1:0]   cap_sum [N][N];
  logic [N*DW-1:0] hl [64];
  logic [N*DW-1:0] hu [64];
  int   done_cyc;
  logic cap_clr1, cap_busy1, cap_busy_done, busy_after;

  task automatic wr_op(input logic sel, input int addr, input int data);
    wr_en   = 1'b1;
    wr_sel  = sel;
    wr_addr = AW'(addr);
    wr_data = DW'(data);
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic load_all();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < K; k++) wr_op(1'b0, i * K + k, a_m[i][k]);
    for (int j = 0; j < N; j++)
      for (int k = 0; k < K; k++) wr_op(1'b1, j * K + k, b_m[k][j]);
  endtask

  task automatic push_expected();
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        int acc;
        acc = 0;
        for (int k = 0; k < K; k++) acc += a_m[i][k] * b_m[k][j];
        sb.push_back(acc % (1 << SW));
      end
    end
  endtask

  // One pass from a negedge; optional write or start pulse injected mid-STREAM.
  task automatic run_pass(input bit mid_wr, input bit mid_start);
    int cyc;
    done_cyc   = -1;
    busy_after = 1'b0;
    for (int c = 0; c < 64; c++) begin
      hl[c] = '0;
      hu[c] = '0;
    end
    push_expected();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (cyc < 40 && done_cyc < 0) begin
      @(posedge clk);
      #1;
      cyc++;
      hl[cyc] = left_bus;
      hu[cyc] = up_bus;
      if (cyc == 1) begin
        cap_clr1  = arr_clr;
        cap_busy1 = busy;
      end
      if (mid_wr && cyc == 5) begin
        wr_en = 1'b1; wr_sel = 1'b0; wr_addr = '0; wr_data = DW'(7);
      end else if (mid_wr && cyc == 6) begin
        wr_en = 1'b0;
      end
      if (mid_start && cyc == 5) start = 1'b1;
      else if (mid_start && cyc == 6) start = 1'b0;
      if (done === 1'b1) begin
        done_cyc      = cyc;
        cap_busy_done = busy;
        for (int i = 0; i < N; i++)
          for (int j = 0; j < N; j++) cap_sum[i][j] = psum[i][j];
      end
    end
    wr_en = 1'b0;
    start = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (busy !== 1'b0) busy_after = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (arr_clr !== 1'b1) begin errors++; $display("FAIL rst_arr_clr: got %b want 1", arr_clr); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", done); end
    checks++; if (left_bus !== '0) begin errors++; $display("FAIL rst_left: got %h want 0", left_bus); end
    checks++; if (up_bus !== '0) begin errors++; $display("FAIL rst_up: got %h want 0", up_bus); end
    rst = 1'b0;
    #1;
    checks++; if (arr_clr !== 1'b1) begin errors++; $display("FAIL rst_clr_hold: got %b want 1", arr_clr); end
    @(posedge clk);
    #1;
    checks++; if (arr_clr !== 1'b0) begin errors++; $display("FAIL rst_clr_release: got %b want 0", arr_clr); end
    @(negedge clk);
  endtask

  task automatic test_identity();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < K; k++) a_m[i][k] = (i == k) ? 1 : 0;
    for (int k = 0; k < K; k++)
      for (int j = 0; j < N; j++) b_m[k][j] = k + j;
    load_all();
    run_pass(1'b0, 1'b0);
    checks++; if (done_cyc != L + 2) begin errors++; $display("FAIL id_done_latency: got %0d want %0d", done_cyc, L + 2); end
    checks++; if (cap_clr1 !== 1'b1) begin errors++; $display("FAIL id_arr_clr: got %b want 1", cap_clr1); end
    checks++; if (cap_busy1 !== 1'b1) begin errors++; $display("FAIL id_busy: got %b want 1", cap_busy1); end
    checks++; if (cap_busy_done !== 1'b0) begin errors++; $display("FAIL id_busy_at_done: got %b want 0", cap_busy_done); end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        int e;
        e = sb.pop_front();
        checks++;
        if (int'(cap_sum[i][j]) != e) begin errors++; $display("FAIL id_sum[%0d][%0d]: got %0d want %0d", i, j, cap_sum[i][j], e); end
      end
  endtask

  task automatic test_skew();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < K; k++) begin a_m[i][k] = 1; b_m[k][i] = 2; end
    load_all();
    run_pass(1'b0, 1'b0);
    checks++; if (hl[1] !== '0 || hu[1] !== '0) begin errors++; $display("FAIL skew_pre_stream: got %h/%h want 0/0", hl[1], hu[1]); end
    checks++; if (hl[L+2] !== '0 || hu[L+2] !== '0) begin errors++; $display("FAIL skew_post_stream: got %h/%h want 0/0", hl[L+2], hu[L+2]); end
    for (int t = 0; t < L; t++) begin
      logic [N*DW-1:0] el, eu;
      el = '0;
      eu = '0;
      for (int i = 0; i < N; i++)
        if (t - i >= 0 && t - i < K) begin
          el[i*DW +: DW] = DW'(1);
          eu[i*DW +: DW] = DW'(2);
        end
      checks++; if (hl[t+2] !== el) begin errors++; $display("FAIL skew_left t=%0d: got %h want %h", t, hl[t+2], el); end
      checks++; if (hu[t+2] !== eu) begin errors++; $display("FAIL skew_up t=%0d: got %h want %h", t, hu[t+2], eu); end
    end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        int e;
        e = sb.pop_front();
        checks++;
        if (int'(cap_sum[i][j]) != e) begin errors++; $display("FAIL skew_sum[%0d][%0d]: got %0d want %0d", i, j, cap_sum[i][j], e); end
      end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < K; k++) begin a_m[i][k] = 15; b_m[k][i] = 15; end
    load_all();
    run_pass(1'b0, 1'b0);
    checks++; if (done_cyc != L + 2) begin errors++; $display("FAIL wrap_done_latency: got %0d want %0d", done_cyc, L + 2); end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        int e;
        e = sb.pop_front();
        checks++;
        if (int'(cap_sum[i][j]) != e) begin errors++; $display("FAIL wrap_sum[%0d][%0d]: got %0d want %0d", i, j, cap_sum[i][j], e); end
      end
  endtask

  task automatic test_write_busy();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < K; k++) a_m[i][k] = (i == k) ? 1 : 0;
    for (int k = 0; k < K; k++)
      for (int j = 0; j < N; j++) b_m[k][j] = k + j + 1;
    load_all();
    for (int p = 0; p < 2; p++) begin
      run_pass(p == 0, 1'b0);
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          int e;
          e = sb.pop_front();
          checks++;
          if (int'(cap_sum[i][j]) != e) begin errors++; $display("FAIL wrbusy_p%0d_sum[%0d][%0d]: got %0d want %0d", p, i, j, cap_sum[i][j], e); end
        end
    end
  endtask

  task automatic test_start_busy();
    for (int k = 0; k < K; k++)
      for (int j = 0; j < N; j++) b_m[k][j] = 3;
    for (int j = 0; j < N; j++)
      for (int k = 0; k < K; k++) wr_op(1'b1, j * K + k, b_m[k][j]);
    run_pass(1'b0, 1'b1);
    checks++; if (busy_after !== 1'b0) begin errors++; $display("FAIL start_busy_requeued: got %b want 0", busy_after); end
    checks++; if (done_cyc != L + 2) begin errors++; $display("FAIL start_busy_latency: got %0d want %0d", done_cyc, L + 2); end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        int e;
        e = sb.pop_front();
        checks++;
        if (int'(cap_sum[i][j]) != e) begin errors++; $display("FAIL start_busy_sum[%0d][%0d]: got %0d want %0d", i, j, cap_sum[i][j], e); end
      end
  endtask

  task automatic test_back_to_back();
    int cyc;
    int dcyc [$];
    logic b12, b13;
    push_expected();
    push_expected();
    start = 1'b1;
    @(negedge clk);
    cyc = 0;
    while (cyc < 40 && dcyc.size() < 2) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 12) b12 = busy;
      if (cyc == 13) begin b13 = busy; start = 1'b0; end
      if (done === 1'b1) begin
        dcyc.push_back(cyc);
        for (int i = 0; i < N; i++)
          for (int j = 0; j < N; j++) begin
            int e;
            e = sb.pop_front();
            checks++;
            if (int'(psum[i][j]) != e) begin errors++; $display("FAIL b2b_sum[%0d][%0d]: got %0d want %0d", i, j, psum[i][j], e); end
          end
      end
    end
    start = 1'b0;
    checks++; if (dcyc.size() != 2) begin errors++; $display("FAIL b2b_done_count: got %0d want 2", dcyc.size()); end
    else begin
      checks++; if (dcyc[0] != L + 2) begin errors++; $display("FAIL b2b_done0: got %0d want %0d", dcyc[0], L + 2); end
      checks++; if (dcyc[1] != 2 * L + 5) begin errors++; $display("FAIL b2b_done1: got %0d want %0d", dcyc[1], 2 * L + 5); end
    end
    checks++; if (b12 !== 1'b0) begin errors++; $display("FAIL b2b_idle_gap: got %b want 0", b12); end
    checks++; if (b13 !== 1'b1) begin errors++; $display("FAIL b2b_restart: got %b want 1", b13); end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int dc0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    dc0 = done_cnt;
    rst = 1'b1;
    #1;
    checks++; if (left_bus !== '0) begin errors++; $display("FAIL rmid_left: got %h want 0", left_bus); end
    checks++; if (up_bus !== '0) begin errors++; $display("FAIL rmid_up: got %h want 0", up_bus); end
    checks++; if (arr_clr !== 1'b1) begin errors++; $display("FAIL rmid_arr_clr: got %b want 1", arr_clr); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b want 0", busy); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    checks++; if (done_cnt != dc0) begin errors++; $display("FAIL rmid_no_done: got %0d pulses want 0", done_cnt - dc0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_idle: got busy %b want 0", busy); end
    for (int i = 0; i < N; i++)
      for (int k = 0; k < K; k++) begin a_m[i][k] = 0; b_m[k][i] = 0; end
    run_pass(1'b0, 1'b0);
    checks++; if (done_cyc != L + 2) begin errors++; $display("FAIL rmid_pass_latency: got %0d want %0d", done_cyc, L + 2); end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        int e;
        e = sb.pop_front();
        checks++;
        if (int'(cap_sum[i][j]) != e) begin errors++; $display("FAIL rmid_store_sum[%0d][%0d]: got %0d want %0d", i, j, cap_sum[i][j], e); end
      end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_skew();
    test_wrap();
    test_write_busy();
    test_start_busy();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
